ifu_fetch: RTL and testbench



---
 rtl/ifu_fetch_pkg.sv | 18 +
 rtl/ifu_fifo.sv | 47 ++++
 rtl/ifu_fetch.sv | 102 ++++++++++
 tb/tb_ifu_fetch.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-unit types and constants: FSM states, EBREAK encoding, default widths.
package ifu_fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam int IFU_PC_WIDTH_DEF  = XLEN;
  localparam int IFU_INS_WIDTH_DEF = ILEN;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DROP
  } ifu_state_t;

endpackage

// File: rtl/ifu_fifo.sv
// Circular instruction queue: DEPTH entries of W bits, wrapping pointers, flush to empty.
module ifu_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 96,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the fetch PC, one outstanding imem request, queued delivery to decode.
// Optional ebreak halt detection enabled by defining IFU_TRAP_DETECT_EN.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                  PC_WIDTH  = IFU_PC_WIDTH_DEF,
  parameter int                  INS_WIDTH = IFU_INS_WIDTH_DEF,
  parameter int                  DEPTH     = 4,
  parameter logic [PC_WIDTH-1:0] RST_PC    = PC_WIDTH'(64'h8000_0000)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [PC_WIDTH-1:0]  imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [INS_WIDTH-1:0] imem_rsp_data,
  input  logic                 redirect_valid,
  input  logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 ins_valid,
  input  logic                 ins_ready,
  output logic [INS_WIDTH-1:0] ins,
  output logic [PC_WIDTH-1:0]  ins_pc,
  output logic                 ebreak_hit
);

  localparam int QW = INS_WIDTH + PC_WIDTH;

  ifu_state_t          state, state_n;
  logic [PC_WIDTH-1:0] fetch_pc, fetch_pc_n;
  logic                halted;
  logic                fire, redir, push, pop;
  logic                q_full, q_empty;
  logic [QW-1:0]       q_rdata;

  assign redir          = redirect_valid && !halted;
  assign imem_req_valid = !rst && (state == REQ) && !q_full && !halted;
  assign imem_req_addr  = fetch_pc;
  assign fire           = imem_req_valid && imem_req_ready;

  // A response landing on a redirect cycle belongs to the old stream.
  assign push      = (state == WAIT) && imem_rsp_valid && !redir;
  assign ins_valid = !rst && !q_empty && !halted;
  assign pop       = ins_valid && ins_ready && !redir;
  assign {ins, ins_pc} = q_rdata;

  ifu_fifo #(
    .DEPTH (DEPTH),
    .W     (QW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .wdata ({imem_rsp_data, fetch_pc}),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    case (state)
      REQ:  if (fire) state_n = WAIT;
      WAIT: if (imem_rsp_valid) begin
        state_n    = REQ;
        fetch_pc_n = fetch_pc + PC_WIDTH'(4);
      end
      DROP: if (imem_rsp_valid) state_n = REQ;
      default: state_n = REQ;
    endcase
    // Any request still owed a response (already outstanding, or firing now) must be absorbed.
    if (redir) begin
      fetch_pc_n = redirect_pc & ~PC_WIDTH'(3);
      state_n    = (((state != REQ) && !imem_rsp_valid) || fire) ? DROP : REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= REQ;
      fetch_pc <= RST_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
    end
  end

`ifdef IFU_TRAP_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst)                                   halted <= 1'b0;
    else if (pop && ins == INS_WIDTH'(EBREAK)) halted <= 1'b1;
  end
  assign ebreak_hit = halted && !rst;
`else
  assign halted     = 1'b0;
  assign ebreak_hit = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus randomized traffic against a stream-level reference.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ins_valid, ins_ready;
  logic [31:0] ins;
  logic [63:0] ins_pc;
  logic        ebreak_hit;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins            (ins),
    .ins_pc         (ins_pc),
    .ebreak_hit     (ebreak_hit)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // stimulus knobs
  int          rdy_pct, pop_pct, lat_min, lat_max;
  bit          redir_go;
  logic [63:0] redir_tgt;
  logic [63:0] trap_addr;

  // memory model and reference stream
  bit          mem_pend;
  logic [63:0] mem_addr;
  int          mem_lat;
  logic [63:0] exp_pc;
  bit          halted_m;
  logic [63:0] fire_addrs[$];
  int          n_pop, cyc_n, first_rsp, first_vld, nf;

  function automatic logic [31:0] memfn(logic [63:0] a);
    if (a == trap_addr) return EBREAK;
    return a[31:0] ^ 32'hC0DE_0003;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; ins_ready = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_ins_valid", ins_valid, 0);
    chk("rst_ebreak", ebreak_hit, 0);
    repeat (2) @(negedge clk);
    chk("rst_req_valid2", imem_req_valid, 0);
    chk("rst_ins_valid2", ins_valid, 0);
    mem_pend = 0; exp_pc = RST_PC; halted_m = 0; redir_go = 0;
    fire_addrs.delete(); n_pop = 0; cyc_n = 0; first_rsp = -1; first_vld = -1;
    rst = 1'b0;
    #1;
  endtask

  // One cycle: drive inputs, predict the edge's events, check, advance the model.
  task automatic tick();
    bit fire, pop, rsp, rdr;
    rsp = mem_pend && (mem_lat == 0);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memfn(mem_addr) : 32'h0;
    imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
    ins_ready      = ($urandom_range(0, 99) < pop_pct);
    redirect_valid = redir_go;
    redirect_pc    = redir_tgt;
    #1;
    fire = imem_req_valid && imem_req_ready;
    pop  = ins_valid && ins_ready;
    rdr  = redir_go && !halted_m;
    chk("ebreak_hit", ebreak_hit, halted_m);
    if (halted_m) begin
      chk("halt_no_req", imem_req_valid, 0);
      chk("halt_no_ins", ins_valid, 0);
    end
    if (fire) begin
      chk("one_outstanding", mem_pend, 0);
      fire_addrs.push_back(imem_req_addr);
    end
    if (rsp && first_rsp < 0)       first_rsp = cyc_n;
    if (ins_valid && first_vld < 0) first_vld = cyc_n;
    if (pop && !rdr) begin
      chk("ins_pc", ins_pc, exp_pc);
      chk("ins", ins, memfn(exp_pc));
`ifdef IFU_TRAP_DETECT_EN
      if (memfn(exp_pc) == EBREAK) halted_m = 1;
`endif
      exp_pc += 64'd4;
      n_pop++;
    end
    if (rdr) exp_pc = redir_tgt & ~64'h3;
    if (rsp) mem_pend = 0;
    else if (mem_pend) mem_lat--;
    if (fire) begin
      mem_pend = 1;
      mem_addr = imem_req_addr;
      mem_lat  = $urandom_range(lat_max, lat_min);
    end
    redir_go = 0;
    cyc_n++;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rdy_pct = 100; pop_pct = 100; lat_min = 0; lat_max = 0;
    redir_go = 0; redir_tgt = '0; trap_addr = 64'h1;

    // streaming with zero-latency memory
    do_reset();
    repeat (6) tick();
    chk("t1_nfire", fire_addrs.size(), 3);
    chk("t1_addr0", fire_addrs[0], RST_PC);
    chk("t1_addr1", fire_addrs[1], RST_PC + 64'd4);
    chk("t1_addr2", fire_addrs[2], RST_PC + 64'd8);
    chk("t1_first_vld", first_vld, first_rsp + 1);

    // decode stalled: queue fills, then one pop frees exactly one slot
    pop_pct = 0;
    do_reset();
    repeat (12) tick();
    chk("t2_nfire", fire_addrs.size(), 4);
    chk("t2_req_idle", imem_req_valid, 0);
    chk("t2_ins_valid", ins_valid, 1);
    pop_pct = 100; tick(); pop_pct = 0;
    repeat (6) tick();
    chk("t2_one_more", fire_addrs.size(), 5);

    // memory not ready: request held stable
    rdy_pct = 0; pop_pct = 100;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", imem_req_valid, 1);
      chk("t3_hold_addr", imem_req_addr, RST_PC);
      tick();
    end
    rdy_pct = 100;
    tick();
    chk("t3_nfire", fire_addrs.size(), 1);
    chk("t3_addr", fire_addrs[0], RST_PC);

    // redirect while waiting; stale response dropped later
    lat_min = 2; lat_max = 2;
    do_reset();
    tick();
    redir_tgt = 64'h8000_1003; redir_go = 1;
    tick();
    tick();
    chk("t4_drop_idle", imem_req_valid, 0);
    tick();
    chk("t4_ins_empty", ins_valid, 0);
    chk("t4_req", imem_req_valid, 1);
    chk("t4_addr", imem_req_addr, 64'h8000_1000);
    lat_min = 0; lat_max = 0;
    repeat (8) tick();
    chk("t4_progress", n_pop >= 2, 1);

    // redirect, response and pop on the same edge
    pop_pct = 0;
    do_reset();
    repeat (7) tick();
    pop_pct = 100; redir_tgt = 64'h8000_2000; redir_go = 1;
    tick();
    chk("t5_flushed", ins_valid, 0);
    chk("t5_req", imem_req_valid, 1);
    chk("t5_addr", imem_req_addr, 64'h8000_2000);
    repeat (8) tick();

    // randomized traffic with redirects and one mid-run reset
    rdy_pct = 70; pop_pct = 60; lat_min = 0; lat_max = 3;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(0, 99) < 4) begin
        redir_go  = 1;
        redir_tgt = 64'h8000_0000 | 64'($urandom_range(0, 16'hffff));
      end
      tick();
    end
    chk("rand_progress", n_pop > 100, 1);

    // ebreak in the stream
    rdy_pct = 100; pop_pct = 100; lat_min = 0; lat_max = 0;
    trap_addr = RST_PC + 64'd4;
    do_reset();
    repeat (6) tick();
`ifdef IFU_TRAP_DETECT_EN
    chk("t6_hit", ebreak_hit, 1);
    chk("t6_ins_off", ins_valid, 0);
    chk("t6_nfire", fire_addrs.size(), 3);
    nf = fire_addrs.size();
    redir_go = 1; redir_tgt = 64'h8000_3000;
    repeat (6) tick();
    chk("t6_no_fetch", fire_addrs.size(), nf);
    chk("t6_sticky", ebreak_hit, 1);
`else
    repeat (6) tick();
    chk("t6_passthru", n_pop, 5);
    chk("t6_no_hit", ebreak_hit, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
